// File: rtl/mac_accumulator_pkg.sv
// Shared constants and state encoding for the product accumulator.
package mac_accumulator_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam int DEFAULT_COUNT = 4;
    localparam int DEFAULT_ACC_W = 10;
    localparam int PROD_W        = 8;

endpackage

// File: rtl/mac_accumulator.sv
// Sums COUNT consecutive 8-bit products into one result handed off over valid/ready.
// The sum wraps modulo 2^ACC_W; any wrap within a group is reported on ovf.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int COUNT = DEFAULT_COUNT,
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] product,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CNT_W = (COUNT > 2) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    // Wrapping add; the MSB of the result is the carry out of the ACC_W-bit sum.
    function automatic logic [ACC_W:0] add_wrap(input logic [ACC_W-1:0] a,
                                                input logic [PROD_W-1:0] p);
        return {1'b0, a} + (ACC_W+1)'(p);
    endfunction

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_int;
    logic              accept;
    logic              last;
    logic [ACC_W:0]    acc_next;

    assign accept   = in_valid & in_ready;
    assign last     = (cnt == CNT_LAST);
    assign acc_next = add_wrap(acc, product);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                in_ready = ~rst;
                if (accept && last) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
        if (clear) state_d = ST_ACCUM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_ACCUM;
        else     state_q <= state_d;
    end

    // clear wins over an accept in the same cycle, so that product is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            ovf_int <= 1'b0;
            sum     <= '0;
            ovf     <= 1'b0;
        end else if (clear) begin
            acc     <= '0;
            cnt     <= '0;
            ovf_int <= 1'b0;
        end else if (accept) begin
            if (last) begin
                sum     <= acc_next[ACC_W-1:0];
                ovf     <= ovf_int | acc_next[ACC_W];
                acc     <= '0;
                cnt     <= '0;
                ovf_int <= 1'b0;
            end else begin
                acc     <= acc_next[ACC_W-1:0];
                cnt     <= cnt + CNT_W'(1);
                ovf_int <= ovf_int | acc_next[ACC_W];
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench: two instances (ACC_W=10 and ACC_W=9) share one stimulus stream.
module tb_mac_accumulator;

    logic       clk;
    logic       rst;
    logic [7:0] product;
    logic       in_valid;
    logic       clear;
    logic       out_ready;

    logic       in_ready_a, ovf_a, out_valid_a;
    logic [9:0] sum_a;
    logic       in_ready_b, ovf_b, out_valid_b;
    logic [8:0] sum_b;

    int tests = 0;
    int fails = 0;

    mac_accumulator #(.COUNT(4), .ACC_W(10)) dut_a (
        .clk(clk), .rst(rst), .product(product), .in_valid(in_valid),
        .in_ready(in_ready_a), .clear(clear), .sum(sum_a), .ovf(ovf_a),
        .out_valid(out_valid_a), .out_ready(out_ready)
    );

    mac_accumulator #(.COUNT(4), .ACC_W(9)) dut_b (
        .clk(clk), .rst(rst), .product(product), .in_valid(in_valid),
        .in_ready(in_ready_b), .clear(clear), .sum(sum_b), .ovf(ovf_b),
        .out_valid(out_valid_b), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] p);
        product  = p;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; product = '0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        #1 rst = 1'b1;
        tick();
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_sum", sum_a, 0);
        chk("rst_ovf", ovf_a, 0);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", in_ready_a, 1);
        tick();

        // Group of 225s: 900 fits in 10 bits, wraps to 388 in 9 bits
        out_ready = 1'b1;
        send(225); send(225); send(225);
        chk("t1_not_yet_valid", out_valid_a, 0);
        send(225);
        chk("t1_valid", out_valid_a, 1);
        chk("t1_sum", sum_a, 900);
        chk("t1_ovf", ovf_a, 0);
        chk("t2_sum_w9", sum_b, 388);
        chk("t2_ovf_w9", ovf_b, 1);
        chk("t1_hold_in_ready", in_ready_a, 0);
        tick();
        chk("t1_release_valid", out_valid_a, 0);
        chk("t1_release_in_ready", in_ready_a, 1);

        send(1); send(2); send(3); send(4);
        chk("t2_sum_a", sum_a, 10);
        chk("t2_sum_w9_next", sum_b, 10);
        chk("t2_ovf_sticky_cleared", ovf_b, 0);
        tick();

        // Backpressure while in_valid stays high
        out_ready = 1'b0;
        send(6); send(10); send(0);
        product = 20; in_valid = 1'b1;
        tick();
        product = 99;
        for (int i = 0; i < 3; i++) begin
            chk("t3_bp_in_ready", in_ready_a, 0);
            chk("t3_bp_valid", out_valid_a, 1);
            chk("t3_bp_sum", sum_a, 36);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t3_after_valid", out_valid_a, 0);
        chk("t3_after_in_ready", in_ready_a, 1);

        // Idle gaps do not advance the count
        send(5); product = 200; tick(); tick();
        send(7); tick();
        send(9);
        chk("t4_gap_not_valid", out_valid_a, 0);
        send(11);
        chk("t4_gap_valid", out_valid_a, 1);
        chk("t4_gap_sum", sum_a, 32);
        tick();

        // clear mid-group drops the partial and the coincident product
        send(10); send(20);
        clear = 1'b1; product = 50; in_valid = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0;
        send(1); send(1); send(1); send(1);
        chk("t5_valid", out_valid_a, 1);
        chk("t5_sum", sum_a, 4);
        clear = 1'b1; out_ready = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_clear_hold_valid", out_valid_a, 0);
        chk("t5_clear_hold_in_ready", in_ready_a, 1);

        // Asynchronous reset between edges
        send(50); send(50); send(50);
        #2 rst = 1'b1;
        #1 chk("t6_async_in_ready", in_ready_a, 0);
        chk("t6_async_valid", out_valid_a, 0);
        rst = 1'b0;
        tick();
        out_ready = 1'b0;
        send(2); send(2); send(2); send(2);
        chk("t6_valid", out_valid_a, 1);
        chk("t6_sum", sum_a, 8);
        #2 rst = 1'b1;
        #1 chk("t6_hold_rst_valid", out_valid_a, 0);
        chk("t6_hold_rst_sum", sum_a, 0);
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
